alu_result_logger: RTL and testbench

- Self-sequencing engine that sweeps every ALU operation over one latched operand pair and writes each result to a single-port 1RW SRAM at consecutive addresses.
- Optionally reads every result back and compares it against a recomputed value, counting mismatches.
- Sits between a host or testbench controller (start/done handshake) and a 1RW SRAM macro such as the 8x512 instance.
- Generalises the manual ALU-to-RAM stepping into a parametrised, synthesizable block.

---
 rtl/alu_result_logger_pkg.sv | 25 ++
 rtl/alu_result_logger_alu_op_eval.sv | 27 ++
 rtl/alu_result_logger.sv | 211 +++++++++++++++++++++
 tb/tb_alu_result_logger.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_logger_pkg.sv
// Shared types and defaults for the ALU result logger.
//   alu_op_e       : fixed ALU opcode assignments (opcodes >= 4 evaluate as XOR)
//   logger_state_e : sequencing FSM states
// Optional readback pass is enabled by defining ALU_RESULT_LOGGER_READBACK_EN.
package alu_result_logger_pkg;

  localparam int unsigned ALU_SEL_WIDTH_DEF = 2;
  localparam int unsigned ALU_NUM_OPS_DEF   = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } logger_state_e;

endpackage

// File: rtl/alu_result_logger_alu_op_eval.sv
// Combinational ALU evaluator shared by the write path and the readback check.
// Ports:
//   i_op       : opcode (0 ADD, 1 SUB, 2 AND, 3 OR, >=4 XOR)
//   i_a, i_b   : operands
//   o_result_c : combinational result, wraps modulo 2^width_p
module alu_op_eval
  import alu_result_logger_pkg::*;
#(
  parameter int unsigned width_p     = 8,
  parameter int unsigned sel_width_p = ALU_SEL_WIDTH_DEF
) (
  input  logic [sel_width_p-1:0] i_op,
  input  logic [width_p-1:0]     i_a,
  input  logic [width_p-1:0]     i_b,
  output logic [width_p-1:0]     o_result_c
);

  // Ordered checks keep narrow opcode widths well defined.
  always_comb begin
    o_result_c = i_a ^ i_b;
    if (i_op == sel_width_p'(ALU_ADD))      o_result_c = i_a + i_b;
    else if (i_op == sel_width_p'(ALU_SUB)) o_result_c = i_a - i_b;
    else if (i_op == sel_width_p'(ALU_AND)) o_result_c = i_a & i_b;
    else if (i_op == sel_width_p'(ALU_OR))  o_result_c = i_a | i_b;
  end

endmodule

// File: rtl/alu_result_logger.sv
// Sweeps every ALU opcode over one latched operand pair and writes each result
// to consecutive addresses of a 1RW SRAM. With ALU_RESULT_LOGGER_READBACK_EN
// defined, the results are read back and compared, counting mismatches.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start_i              : start request, accepted only in IDLE
//   a_i, b_i, base_addr_i: operands and first address, latched on start
//   busy_o, done_o       : busy in every non-IDLE state; one-cycle done pulse
//   err_cnt_o            : saturating readback mismatch count of the last run
//   sram_*_o, sram_rd_i  : 1RW SRAM interface (read data valid one cycle later)
module alu_result_logger
  import alu_result_logger_pkg::*;
#(
  parameter int unsigned width_p      = 8,
  parameter int unsigned addr_width_p = 9,
  parameter int unsigned num_ops_p    = ALU_NUM_OPS_DEF,
  parameter int unsigned sel_width_p  = ALU_SEL_WIDTH_DEF,
  parameter int unsigned err_width_p  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [width_p-1:0]      a_i,
  input  logic [width_p-1:0]      b_i,
  input  logic [addr_width_p-1:0] base_addr_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [err_width_p-1:0]  err_cnt_o,
  output logic                    sram_ce_o,
  output logic                    sram_we_o,
  output logic [addr_width_p-1:0] sram_addr_o,
  output logic [width_p-1:0]      sram_wd_o,
  output logic [width_p-1:0]      sram_w_mask_o,
  input  logic [width_p-1:0]      sram_rd_i
);

  localparam logic [sel_width_p-1:0] LastK = sel_width_p'(num_ops_p - 1);

  logger_state_e           r_state;
  logic [sel_width_p-1:0]  r_k;
  logic [width_p-1:0]      r_a;
  logic [width_p-1:0]      r_b;
  logic [addr_width_p-1:0] r_base;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_ce;
  logic                    r_we;
  logic [addr_width_p-1:0] r_addr;
  logic [width_p-1:0]      r_wd;

  logic [sel_width_p-1:0]  w_k_inc;
  logic [sel_width_p-1:0]  w_wr_op;
  logic [width_p-1:0]      w_wr_a;
  logic [width_p-1:0]      w_wr_b;
  logic [width_p-1:0]      w_wr_data;

  // Outputs are registered one cycle ahead, so the evaluator works on the
  // index (and operands) that will be on the bus in the next cycle.
  assign w_k_inc = r_k + sel_width_p'(1);
  assign w_wr_op = (r_state == ST_IDLE) ? '0  : w_k_inc;
  assign w_wr_a  = (r_state == ST_IDLE) ? a_i : r_a;
  assign w_wr_b  = (r_state == ST_IDLE) ? b_i : r_b;

  alu_op_eval #(
    .width_p     (width_p),
    .sel_width_p (sel_width_p)
  ) u_wr_eval (
    .i_op       (w_wr_op),
    .i_a        (w_wr_a),
    .i_b        (w_wr_b),
    .o_result_c (w_wr_data)
  );

`ifdef ALU_RESULT_LOGGER_READBACK_EN
  logic [err_width_p-1:0] r_err;
  logic [width_p-1:0]     r_exp;
  logic                   r_cmp_vld;
  logic [width_p-1:0]     w_exp;

  // Expected value for the read currently on the bus.
  alu_op_eval #(
    .width_p     (width_p),
    .sel_width_p (sel_width_p)
  ) u_exp_eval (
    .i_op       (r_k),
    .i_a        (r_a),
    .i_b        (r_b),
    .o_result_c (w_exp)
  );

  assign err_cnt_o = r_err;
`else
  logic w_unused_rd;

  assign w_unused_rd = ^sram_rd_i;
  assign err_cnt_o   = '0;
`endif

  // Sequencer: state, index and all bus outputs in one registered process.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_base    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ce      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wd      <= '0;
`ifdef ALU_RESULT_LOGGER_READBACK_EN
      r_err     <= '0;
      r_exp     <= '0;
      r_cmp_vld <= 1'b0;
`endif
    end else begin
`ifdef ALU_RESULT_LOGGER_READBACK_EN
      // Compare the previous read while the next one issues.
      if (r_cmp_vld && (sram_rd_i != r_exp) && (r_err != '1)) begin
        r_err <= r_err + err_width_p'(1);
      end
`endif
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_WRITE;
            r_k     <= '0;
            r_a     <= a_i;
            r_b     <= b_i;
            r_base  <= base_addr_i;
            r_busy  <= 1'b1;
            r_ce    <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= base_addr_i;
            r_wd    <= w_wr_data;
`ifdef ALU_RESULT_LOGGER_READBACK_EN
            r_err     <= '0;
            r_cmp_vld <= 1'b0;
`endif
          end
        end

        ST_WRITE: begin
          if (r_k == LastK) begin
            r_k  <= '0;
            r_we <= 1'b0;
`ifdef ALU_RESULT_LOGGER_READBACK_EN
            r_state <= ST_READ;
            r_addr  <= r_base;
`else
            r_state <= ST_DONE;
            r_ce    <= 1'b0;
            r_done  <= 1'b1;
`endif
          end else begin
            r_k    <= w_k_inc;
            r_addr <= r_base + addr_width_p'(w_k_inc);
            r_wd   <= w_wr_data;
          end
        end

`ifdef ALU_RESULT_LOGGER_READBACK_EN
        ST_READ: begin
          r_exp     <= w_exp;
          r_cmp_vld <= 1'b1;
          if (r_k == LastK) begin
            r_state <= ST_DRAIN;
            r_k     <= '0;
            r_ce    <= 1'b0;
          end else begin
            r_k    <= w_k_inc;
            r_addr <= r_base + addr_width_p'(w_k_inc);
          end
        end

        ST_DRAIN: begin
          r_cmp_vld <= 1'b0;
          r_state   <= ST_DONE;
          r_done    <= 1'b1;
        end
`endif

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_k     <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ce    <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign sram_ce_o     = r_ce;
  assign sram_we_o     = r_we;
  assign sram_addr_o   = r_addr;
  assign sram_wd_o     = r_wd;
  assign sram_w_mask_o = '1;

endmodule

// File: tb/tb_alu_result_logger.sv
// Directed, table-driven bench for alu_result_logger with a behavioural 1RW
// SRAM that can corrupt selected read addresses (XOR 0x80).
module tb_alu_result_logger;

  localparam int N = 4;
`ifdef ALU_RESULT_LOGGER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int DONE_CYC = RB ? (2 * N + 2) : (N + 1);

  typedef struct {
    logic [7:0]      a;
    logic [7:0]      b;
    logic [8:0]      base;
    logic [3:0][7:0] d;
    logic [3:0]      corrupt;
    logic [7:0]      err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [7:0] a_i, b_i;
  logic [8:0] base_addr_i;
  logic       busy_o, done_o;
  logic [7:0] err_cnt_o;
  logic       sram_ce_o, sram_we_o;
  logic [8:0] sram_addr_o;
  logic [7:0] sram_wd_o, sram_w_mask_o;
  logic [7:0] sram_rd_i;

  alu_result_logger dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .base_addr_i   (base_addr_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_cnt_o     (err_cnt_o),
    .sram_ce_o     (sram_ce_o),
    .sram_we_o     (sram_we_o),
    .sram_addr_o   (sram_addr_o),
    .sram_wd_o     (sram_wd_o),
    .sram_w_mask_o (sram_w_mask_o),
    .sram_rd_i     (sram_rd_i)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous 1RW SRAM with per-address read corruption.
  logic [7:0] mem [512];
  bit         corrupt [512];

  always @(posedge clk) begin
    if (sram_ce_o) begin
      if (sram_we_o) mem[sram_addr_o] <= sram_wd_o & sram_w_mask_o;
      else           sram_rd_i <= mem[sram_addr_o] ^ (corrupt[sram_addr_o] ? 8'h80 : 8'h00);
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [8:0] base,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] d3, input logic [3:0] cor, input logic [7:0] err);
    vec_t v;
    v.a = a; v.b = b; v.base = base;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.corrupt = cor;
    v.err = RB ? err : 8'h00;
    return v;
  endfunction

  logic [8:0] wr_a_q [$];
  logic [7:0] wr_d_q [$];
  logic [8:0] rd_a_q [$];

  task automatic run(input vec_t v, input int sp1, input int sp2, input string tag);
    int first_wr, last_wr, first_rd, done_cnt, done_cyc;
    logic [7:0] err_at_done;
    bit finished;
    logic [8:0] ea;
    first_wr = -1; last_wr = -1; first_rd = -1; done_cnt = 0; done_cyc = -1;
    err_at_done = 8'h00; finished = 1'b0;
    wr_a_q.delete(); wr_d_q.delete(); rd_a_q.delete();
    for (int i = 0; i < 512; i++) corrupt[i] = 1'b0;
    for (int i = 0; i < N; i++) if (v.corrupt[i]) corrupt[9'(v.base + 9'(i))] = 1'b1;

    @(negedge clk);
    start_i = 1'b1; a_i = v.a; b_i = v.b; base_addr_i = v.base;
    @(posedge clk); #1;
    start_i = 1'b0; a_i = ~v.a; b_i = ~v.b; base_addr_i = ~v.base;
    chk({tag, " err_cleared"}, 32'(err_cnt_o), 32'd0);

    for (int c = 1; c <= 60; c++) begin
      if (sram_ce_o && sram_we_o) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        wr_a_q.push_back(sram_addr_o);
        wr_d_q.push_back(sram_wd_o);
      end
      if (sram_ce_o && !sram_we_o) begin
        if (first_rd < 0) first_rd = c;
        rd_a_q.push_back(sram_addr_o);
      end
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          err_at_done = err_cnt_o;
        end
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        start_i = 1'b0;
        chk({tag, " busy_after_done"}, 32'(busy_o), 32'd0);
        chk({tag, " done_one_cycle"}, 32'(done_o), 32'd0);
        chk({tag, " err_hold"}, 32'(err_cnt_o), 32'(v.err));
        finished = 1'b1;
        break;
      end
      start_i = (c == sp1) || (c == sp2);
      if (start_i) begin
        a_i = 8'h77; b_i = 8'h22; base_addr_i = 9'h055;
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    if (!finished) begin
      n_vec++; n_bad++;
      $display("FAIL %s timeout: no done_o within 60 cycles", tag);
    end
    @(posedge clk); #1;
    chk({tag, " still_idle"}, 32'(busy_o), 32'd0);

    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(DONE_CYC));
    chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, " err_at_done"}, 32'(err_at_done), 32'(v.err));
    chk({tag, " first_write_cycle"}, 32'(first_wr), 32'd1);
    chk({tag, " last_write_cycle"}, 32'(last_wr), 32'(N));
    chk({tag, " write_count"}, 32'(wr_a_q.size()), 32'(N));
    for (int i = 0; i < N && i < wr_a_q.size(); i++) begin
      ea = 9'(v.base + 9'(i));
      chk($sformatf("%s wr_addr[%0d]", tag, i), 32'(wr_a_q[i]), 32'(ea));
      chk($sformatf("%s wr_data[%0d]", tag, i), 32'(wr_d_q[i]), 32'(v.d[i]));
    end
    chk({tag, " read_count"}, 32'(rd_a_q.size()), RB ? 32'(N) : 32'd0);
    if (RB) begin
      chk({tag, " first_read_cycle"}, 32'(first_rd), 32'(N + 1));
      for (int i = 0; i < N && i < rd_a_q.size(); i++) begin
        ea = 9'(v.base + 9'(i));
        chk($sformatf("%s rd_addr[%0d]", tag, i), 32'(rd_a_q[i]), 32'(ea));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    tbl[0] = mk(8'h01, 8'h03, 9'h000, 8'h04, 8'hFE, 8'h01, 8'h03, 4'b0000, 8'd0);
    tbl[1] = mk(8'hFF, 8'h01, 9'h1FE, 8'h00, 8'hFE, 8'h01, 8'hFF, 4'b0000, 8'd0);
    tbl[2] = mk(8'h5A, 8'h3C, 9'h010, 8'h96, 8'h1E, 8'h18, 8'h7E, 4'b0100, 8'd1);
    tbl[3] = mk(8'h80, 8'h80, 9'h100, 8'h00, 8'h00, 8'h80, 8'h80, 4'b1111, 8'd4);
    tbl[4] = mk(8'hF0, 8'h0F, 9'h0FF, 8'hFF, 8'hE1, 8'h00, 8'hFF, 4'b0000, 8'd0);

    reset = 1'b1; start_i = 1'b0; a_i = 8'h00; b_i = 8'h00; base_addr_i = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset ce", 32'(sram_ce_o), 32'd0);
    chk("reset we", 32'(sram_we_o), 32'd0);
    chk("reset addr", 32'(sram_addr_o), 32'd0);
    chk("reset wd", 32'(sram_wd_o), 32'd0);
    chk("reset err", 32'(err_cnt_o), 32'd0);
    chk("wmask", 32'(sram_w_mask_o), 32'hFF);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run(tbl[i], -1, -1, $sformatf("vec%0d", i));

    // Start pulses during WRITE and during the DONE pulse must both be ignored.
    run(tbl[0], 3, DONE_CYC, "start_busy");

    // Reset in cycle 5 aborts the run at the next edge.
    @(negedge clk);
    start_i = 1'b1; a_i = 8'h01; b_i = 8'h03; base_addr_i = 9'h000;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset busy", 32'(busy_o), 32'd0);
    chk("midreset ce", 32'(sram_ce_o), 32'd0);
    chk("midreset done", 32'(done_o), 32'd0);
    chk("midreset err", 32'(err_cnt_o), 32'd0);
    reset = 1'b0;
    run(tbl[0], -1, -1, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
